// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage.
//   pipe_state_e  : occupancy state, encoded as {skid_valid, out_valid}
//   ID_EX_CTRL_W  : default width of the control field
//   ID_EX_DATA_W  : default width of the payload field
package pipe_pkg;

  localparam int ID_EX_CTRL_W = 10;
  localparam int ID_EX_DATA_W = 138;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register behind the ID/EX output register.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture d, entry becomes valid
//   unload        : entry moved out, becomes invalid
//   clear         : drop the entry (squash); wins over load/unload
//   d / q         : entry data in / out (W bits)
//   valid         : entry holds an instruction
module pipe_skid_buf #(
  parameter int W = 148
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, hazard stall,
// branch flush and a saturating stall-cycle counter.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_ctrl/in_data : upstream (ID) side
//   stall, flush                  : hazard hold / squash requests
//   out_valid/out_ready/out_ctrl/out_data : downstream (EX) side
//   stall_cnt                     : saturating count of stalled cycles
// Build option: PIPE_STAGE_SKID_EN adds a one-entry skid register so
// in_ready no longer depends combinationally on out_ready.
//
// state | meaning
// EMPTY | no instruction held, out_ctrl forced to 0
// FULL  | output register holds a valid instruction
// SKID  | output and skid entry both valid (skid build only)
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0] data_d;
  logic              accept, emit;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic                     skid_valid, skid_load, skid_unload, skid_clear;
  logic [CTRL_W+DATA_W-1:0] skid_q;

  pipe_skid_buf #(.W(CTRL_W + DATA_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .d      ({in_ctrl, in_data}),
    .q      (skid_q),
    .valid  (skid_valid)
  );

  assign in_ready = !skid_valid && !stall && !flush;
`else
  assign in_ready = (!out_valid || out_ready) && !stall && !flush;
`endif

  always_comb begin
    state_d = state_q;
    ctrl_d  = out_ctrl;
    data_d  = out_data;
`ifdef PIPE_STAGE_SKID_EN
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
`endif
    if (flush) begin
      // payload is left alone; only the control field is squashed
      state_d = EMPTY;
      ctrl_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else if (!stall) begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
          end
        end
        FULL: begin
          if (emit && accept) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
          end else if (emit) begin
            state_d = EMPTY;
            ctrl_d  = '0;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (accept) begin
            state_d   = SKID;
            skid_load = 1'b1;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (emit) begin
            state_d     = FULL;
            ctrl_d      = skid_q[CTRL_W+DATA_W-1 -: CTRL_W];
            data_d      = skid_q[DATA_W-1:0];
            skid_unload = 1'b1;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          ctrl_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      out_ctrl <= '0;
      out_data <= '0;
    end else begin
      state_q  <= state_d;
      out_ctrl <= ctrl_d;
      out_data <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 10: width of the control field; the field is cleared on a bubble.
REQ-002 SHALL have parameter DATA_W, default 138: width of the payload field (operands, immediate, pc+4, register ids); the field is never cleared.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall-statistics counter.
REQ-004 SHALL have port clk  in  1: single clock, rising edge; the one clock for the design.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  in  1: upstream (ID) holds a valid instruction.
REQ-007 SHALL have port in_ready  out  1: stage accepts in_* this cycle.
REQ-008 SHALL have port in_ctrl  in  CTRL_W: control bits (RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, ALUop).
REQ-009 SHALL have port in_data  in  DATA_W: payload.
REQ-010 SHALL have port stall  in  1: hazard-unit hold request.
REQ-011 SHALL have port flush  in  1: branch/jump squash request.
REQ-012 SHALL have port out_valid  out  1: EX-side instruction is valid.
REQ-013 SHALL have port out_ready  in  1: downstream (EX) consumes out_* this cycle.
REQ-014 SHALL have port out_ctrl  out  CTRL_W: registered control bits.
REQ-015 SHALL have port out_data  out  DATA_W: registered payload.
REQ-016 SHALL have port stall_cnt  out  CNT_W: count of stalled cycles.

Function
REQ-017 SHALL define accept as in_valid && in_ready, and emit as out_valid && out_ready.
REQ-018 SHALL force in_ready to 0 while stall=1 or flush=1.
REQ-019 SHALL, on accept, register in_ctrl/in_data to the output (or the skid, see REQ-030) at the next clock edge, with latency 1 cycle.
REQ-020 SHALL, when emit occurs and there is no accept, set out_valid=0 next cycle; out_data holds its value and out_ctrl becomes 0 (bubble).
REQ-021 SHALL keep out_ctrl equal to 0 whenever out_valid=0, so a bubble never writes to memory or the register file.
REQ-022 SHALL, when out_valid=1 and out_ready=0, hold out_ctrl/out_data/out_valid stable until emit.
REQ-023 SHALL, when stall=1 and flush=0, hold all outputs and internal storage unchanged; an emit in the same cycle is ignored (not consumed).
REQ-024 SHALL, when flush=1, on the next edge set out_valid=0 and out_ctrl=0, discard skid contents, and leave out_data unchanged; flush overrides stall, accept and emit.
REQ-025 SHALL increment stall_cnt on every cycle with stall=1 and flush=0, saturating at 2^CNT_W-1 with no wrap.
REQ-026 SHALL form the state machine from out_valid/skid_valid: EMPTY (0,0), FULL (1,0), SKID (1,1, only with the macro).
- EMPTY->FULL: accept.
- FULL->EMPTY: emit without accept.
- FULL->FULL: emit with accept, or no activity.
- FULL->SKID: accept without emit.
- SKID->FULL: emit; the skid entry moves to the output.
- any->EMPTY: flush.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, clear out_valid, out_ctrl, out_data, skid storage and stall_cnt; state becomes EMPTY.
REQ-028 SHALL give rst priority over flush, stall and all handshakes; an in-flight instruction is dropped.
REQ-029 SHALL drive in_ready=1 in the first cycle after rst deasserts (unless stall or flush is asserted).

Configuration
REQ-030 SHALL, when PIPE_STAGE_SKID_EN is defined, include a one-entry skid register.
- in_ready = !skid_valid && !stall && !flush, driven from flops only.
- Sustains one instruction per cycle with out_ready deasserting.
REQ-031 SHALL, when PIPE_STAGE_SKID_EN is undefined, omit the skid register and the SKID state.
- in_ready = (!out_valid || out_ready) && !stall && !flush, a combinational path from out_ready.

Structure
REQ-032 SHALL place the pipe_state_e enum (EMPTY/FULL/SKID) and default width constants (ID_EX_CTRL_W, ID_EX_DATA_W) in shared package pipe_pkg.
REQ-033 SHALL implement the skid entry as sub-module pipe_skid_buf (width CTRL_W+DATA_W, load/unload/clear), instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-034 SHALL cover streaming: in_valid=1 for 4 cycles, ctrl 0x3FF..0x3FC, data 1..4, out_ready=1.
- Required: out_valid=1 on cycles 1-4 with data 1..4 in order, in_ready=1 throughout.
REQ-035 SHALL cover stall: FULL with data 7, stall=1 for 3 cycles.
- Required: out_data=7 held, in_ready=0, stall_cnt goes 0->3.
- On release, the next input is accepted.
REQ-036 SHALL cover flush: FULL with ctrl 0x155, flush=1 and stall=1 together.
- Required: next cycle out_valid=0, out_ctrl=0, stall_cnt unchanged.
REQ-037 SHALL cover backpressure with the macro: out_ready=0 while accepting data A then B.
- Required: A held at output, B in skid, in_ready=0.
- out_ready=1 -> A then B emitted with no loss or duplication.
REQ-038 SHALL cover reset mid-operation: rst=1 in state SKID (with the macro) or FULL.
- Required: next cycle out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
REQ-039 SHALL cover saturation: CNT_W=4, stall=1 for 20 cycles.
- Required: stall_cnt stops at 15.
